pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: N, 32, PC and address width in bits.
REQ-002 Parameter: RESET_VECTOR, 'h00400000, PC value after reset.
REQ-003 Parameter: EXC_VECTOR, 'h80000180, PC value loaded on exception entry.
REQ-004 Parameter: DEPTH, 3, number of tracked downstream stage PCs (at least 1).
REQ-005 Parameter: FLUSH_CYCLES, 2, fetch-suppressed cycles after exception entry (at least 1).
REQ-006 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: enable  in  1  PCWrite from hazard detection; 0 means stall.
REQ-009 Port: redirect_valid  in  1  branch/jump taken this cycle.
REQ-010 Port: redirect_target  in  N  branch/jump destination.
REQ-011 Port: exc_req  in  1  exception request.
REQ-012 Port: exc_stage  in  $clog2(DEPTH) (minimum 1)  index of the stage_pc entry that faulted.
REQ-013 Port: eret  in  1  return from exception.
REQ-014 Port: pc  out  N  current fetch PC.
REQ-015 Port: pc_plus4  out  N  pc+4, combinational.
REQ-016 Port: fetch_valid  out  1  1 when the fetch at pc is architecturally valid.
REQ-017 Port: stage_pc  out  DEPTH*N  tracked PCs, entry 0 in the least significant bits.
REQ-018 Port: epc  out  N  saved exception PC.
REQ-019 Port: bad_addr  out  N  last misaligned redirect target.

Function
REQ-020 The FSM SHALL have two states, RUN and FLUSH, with a flush counter of width $clog2(FLUSH_CYCLES+1).
REQ-021 In RUN, one event per cycle SHALL be applied, highest priority first: exc_req > misaligned redirect > eret > redirect > enable increment > hold.
REQ-022 exc_req in RUN: epc <= stage_pc[exc_stage], pc <= EXC_VECTOR, state <= FLUSH, counter <= FLUSH_CYCLES-1; applies regardless of enable.
REQ-023 Misaligned redirect (redirect_valid=1, redirect_target[1:0] != 0, no exc_req): epc <= pc, bad_addr <= redirect_target, then the same entry actions as REQ-022.
REQ-024 eret in RUN: pc <= epc; applies regardless of enable.
REQ-025 Aligned redirect in RUN: pc <= redirect_target; applies regardless of enable.
REQ-026 Otherwise, with enable=1 the PC SHALL take pc <= pc+4 (wrapping modulo 2^N); with enable=0 all registers hold.
REQ-027 In FLUSH, pc SHALL hold, and exc_req, eret and redirect_valid SHALL be ignored; the counter decrements each cycle, and the state moves to RUN on the cycle the counter equals 0.
REQ-028 fetch_valid SHALL be 1 exactly in RUN.
REQ-029 The tracker SHALL update only on cycles in RUN with enable=1 and no exception entry.
REQ-030 On a tracker update: stage_pc[0] <= pc and stage_pc[k] <= stage_pc[k-1].
REQ-031 An out-of-range exc_stage (at least DEPTH) SHALL select stage_pc[DEPTH-1].
REQ-032 pc_plus4 SHALL be the N-bit truncated sum, with no carry out.

Reset
REQ-033 When reset=1 at a rising edge: pc <= RESET_VECTOR, state <= RUN, counter <= 0, every stage_pc entry <= RESET_VECTOR, epc <= 0, bad_addr <= 0.
REQ-034 reset SHALL override all other inputs, including during FLUSH.
REQ-035 fetch_valid SHALL be 1 in the first cycle after reset is released.

Structure
REQ-036 A shared package SHALL hold the RUN/FLUSH state encoding and the default RESET_VECTOR and EXC_VECTOR constants.
REQ-037 The stage tracker SHALL be a separate sub-module, pc_track_shift, parametrised by N and DEPTH with a shift-enable input.

Verification
REQ-038 Reset, then enable=1 for 3 cycles -> pc = 'h0040000C, stage_pc[0] = 'h00400008, stage_pc[2] = 'h00400000.
REQ-039 pc='h00400010 with enable=0 and redirect_valid=1, target='h00400100 -> next pc = 'h00400100 and stage_pc unchanged.
REQ-040 exc_req=1 with exc_stage=1 and redirect_valid=1 in the same cycle -> epc = old stage_pc[1], pc = 'h80000180, fetch_valid=0 for 2 cycles then 1.
REQ-041 redirect_target='h00400102 -> bad_addr = 'h00400102, epc = the pc at the redirect, pc = 'h80000180, state = FLUSH.
REQ-042 eret at pc='h80000184 with epc='h0040000C -> next pc = 'h0040000C; eret asserted during FLUSH -> ignored.
REQ-043 reset asserted in the first FLUSH cycle -> next cycle pc = 'h00400000, fetch_valid=1; with N=8, pc='hFC and enable=1 -> pc = 'h00.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding and default vectors.

package pc_sequencer_pkg;

   typedef enum logic {
      StRun,
      StFlush
   } seq_state_e;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_track_shift.sv
// Shift register of PCs following the fetch PC down the pipeline.
// Entry 0 sits in the least significant N bits of the flat output.

module pc_track_shift #(
   parameter int unsigned  N            = 32,
   parameter int unsigned  DEPTH        = 3,
   parameter logic [N-1:0] RESET_VECTOR = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift_en_i,
   input  logic [N-1:0]       pc_i,
   output logic [DEPTH*N-1:0] stage_pc_o
);

   logic [DEPTH*N-1:0] stage_d, stage_q;

   always_comb begin
      stage_d = stage_q;
      if (shift_en_i) begin
         stage_d[N-1:0] = pc_i;
         for (int k = 1; k < DEPTH; k++) begin
            stage_d[k*N +: N] = stage_q[(k-1)*N +: N];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= {DEPTH{RESET_VECTOR}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_pc_o = stage_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential/branch/eret PC selection, exception entry with a
// fetch-suppressing flush window, and tracking of downstream stage PCs for EPC capture.

module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned  N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = N'(DEF_RESET_VECTOR),
   parameter logic [N-1:0] EXC_VECTOR   = N'(DEF_EXC_VECTOR),
   parameter int unsigned  DEPTH        = 3,
   parameter int unsigned  FLUSH_CYCLES = 2,
   localparam int unsigned SW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               redirect_valid,
   input  logic [N-1:0]       redirect_target,
   input  logic               exc_req,
   input  logic [SW-1:0]      exc_stage,
   input  logic               eret,
   output logic [N-1:0]       pc,
   output logic [N-1:0]       pc_plus4,
   output logic               fetch_valid,
   output logic [DEPTH*N-1:0] stage_pc,
   output logic [N-1:0]       epc,
   output logic [N-1:0]       bad_addr
);

   localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

   seq_state_e    state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [N-1:0]  pc_d, pc_q;
   logic [N-1:0]  epc_d, epc_q;
   logic [N-1:0]  bad_d, bad_q;

   logic          misaligned;
   logic          exc_entry;
   logic          track_shift;
   logic [N-1:0]  sel_pc;

   assign misaligned  = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign exc_entry   = (state_q == StRun) && (exc_req || misaligned);
   assign track_shift = (state_q == StRun) && enable && !exc_entry;

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + N'(4);
   assign fetch_valid = (state_q == StRun);
   assign epc         = epc_q;
   assign bad_addr    = bad_q;

   // Out-of-range stage indices fall through to the oldest entry.
   always_comb begin
      sel_pc = stage_pc[(DEPTH-1)*N +: N];
      for (int k = 0; k < DEPTH; k++) begin
         if (exc_stage == SW'(k)) begin
            sel_pc = stage_pc[k*N +: N];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      bad_d   = bad_q;
      case (state_q)
         StRun: begin
            if (exc_req) begin
               epc_d   = sel_pc;
               pc_d    = EXC_VECTOR;
               state_d = StFlush;
               cnt_d   = CW'(FLUSH_CYCLES - 1);
            end else if (misaligned) begin
               epc_d   = pc_q;
               bad_d   = redirect_target;
               pc_d    = EXC_VECTOR;
               state_d = StFlush;
               cnt_d   = CW'(FLUSH_CYCLES - 1);
            end else if (eret) begin
               pc_d = epc_q;
            end else if (redirect_valid) begin
               pc_d = redirect_target;
            end else if (enable) begin
               pc_d = pc_plus4;
            end
         end
         StFlush: begin
            if (cnt_q == '0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         cnt_q   <= '0;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         bad_q   <= bad_d;
      end
   end

   pc_track_shift #(
      .N            (N),
      .DEPTH        (DEPTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_track (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (track_shift),
      .pc_i       (pc_q),
      .stage_pc_o (stage_pc)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default 32-bit instance plus an 8-bit instance
// used only for the PC wrap-around case.

module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        exc_req;
   logic [1:0]  exc_stage;
   logic        eret;
   logic [31:0] pc, pc_plus4, epc, bad_addr;
   logic        fetch_valid;
   logic [95:0] stage_pc;

   logic        en8;
   logic [7:0]  pc8, pc8_plus4, epc8, bad8;
   logic        fv8;
   logic [23:0] stage8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .exc_req         (exc_req),
      .exc_stage       (exc_stage),
      .eret            (eret),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .fetch_valid     (fetch_valid),
      .stage_pc        (stage_pc),
      .epc             (epc),
      .bad_addr        (bad_addr)
   );

   pc_sequencer #(
      .N            (8),
      .RESET_VECTOR (8'hF8),
      .EXC_VECTOR   (8'h80)
   ) dut8 (
      .clk             (clk),
      .reset           (reset),
      .enable          (en8),
      .redirect_valid  (1'b0),
      .redirect_target (8'h00),
      .exc_req         (1'b0),
      .exc_stage       (2'b00),
      .eret            (1'b0),
      .pc              (pc8),
      .pc_plus4        (pc8_plus4),
      .fetch_valid     (fv8),
      .stage_pc        (stage8),
      .epc             (epc8),
      .bad_addr        (bad8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      exc_req = 1'b0; exc_stage = '0; eret = 1'b0; en8 = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_pc",  pc,             32'h0040_0000);
      chk("rst_fv",  32'(fetch_valid), 32'd1);
      chk("rst_s0",  stage_pc[31:0],  32'h0040_0000);
      chk("rst_s2",  stage_pc[95:64], 32'h0040_0000);
      chk("rst_epc", epc,            32'h0);
      chk("rst_bad", bad_addr,       32'h0);

      enable = 1'b1;
      step(); step(); step();
      chk("inc3_pc", pc,              32'h0040_000C);
      chk("inc3_s0", stage_pc[31:0],  32'h0040_0008);
      chk("inc3_s2", stage_pc[95:64], 32'h0040_0000);
      step();
      chk("inc4_pc", pc, 32'h0040_0010);

      // Redirect while stalled: pc moves, tracker frozen.
      enable = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
      step();
      chk("redir_pc", pc,              32'h0040_0100);
      chk("redir_s0", stage_pc[31:0],  32'h0040_000C);
      chk("redir_s1", stage_pc[63:32], 32'h0040_0008);
      chk("redir_p4", pc_plus4,        32'h0040_0104);
      redirect_valid = 1'b0;
      step();
      chk("stall_pc", pc, 32'h0040_0100);

      // Exception beats a simultaneous aligned redirect.
      exc_req = 1'b1; exc_stage = 2'd1; redirect_valid = 1'b1;
      redirect_target = 32'h0040_0200; enable = 1'b1;
      step();
      chk("exc_epc", epc,              32'h0040_0008);
      chk("exc_pc",  pc,               32'h8000_0180);
      chk("exc_fv0", 32'(fetch_valid), 32'd0);
      chk("exc_s0",  stage_pc[31:0],   32'h0040_000C);
      exc_req = 1'b0; redirect_valid = 1'b0; eret = 1'b1;
      step();
      chk("fl1_fv", 32'(fetch_valid), 32'd0);
      chk("fl1_pc", pc,               32'h8000_0180);
      step();
      chk("fl2_fv",  32'(fetch_valid), 32'd1);
      chk("fl2_pc",  pc,               32'h8000_0180);
      chk("fl2_epc", epc,              32'h0040_0008);
      eret = 1'b0;
      step();
      chk("hnd_pc", pc,             32'h8000_0184);
      chk("hnd_s0", stage_pc[31:0], 32'h8000_0180);
      eret = 1'b1;
      step();
      chk("eret_pc", pc, 32'h0040_0008);
      eret = 1'b0;
      step();
      chk("post_eret_pc", pc, 32'h0040_000C);

      // Misaligned redirect enters the exception path.
      redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
      step();
      chk("mis_bad", bad_addr,         32'h0040_0102);
      chk("mis_epc", epc,              32'h0040_000C);
      chk("mis_pc",  pc,               32'h8000_0180);
      chk("mis_fv",  32'(fetch_valid), 32'd0);
      chk("mis_s0",  stage_pc[31:0],   32'h0040_0008);

      // Reset during the first flush cycle.
      redirect_valid = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rfl_pc",  pc,               32'h0040_0000);
      chk("rfl_fv",  32'(fetch_valid), 32'd1);
      chk("rfl_bad", bad_addr,         32'h0);
      chk("rfl_s1",  stage_pc[63:32],  32'h0040_0000);

      // Out-of-range stage index selects the oldest entry.
      enable = 1'b1;
      step(); step(); step();
      chk("oor_pre_s1", stage_pc[63:32], 32'h0040_0004);
      exc_req = 1'b1; exc_stage = 2'd3;
      step();
      exc_req = 1'b0;
      chk("oor_epc", epc, 32'h0040_0000);
      step(); step();
      chk("oor_fv", 32'(fetch_valid), 32'd1);

      // 8-bit instance: wrap modulo 2^N.
      en8 = 1'b1;
      step();
      chk("w8_pc_fc", 32'(pc8),       32'h0000_00FC);
      chk("w8_p4",    32'(pc8_plus4), 32'h0000_0000);
      step();
      chk("w8_pc_00", 32'(pc8),       32'h0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
